// File: rtl/button_cond_if.sv
// Button conditioner bus: raw pads in, debounced level and event strobes out.
// The master side drives the pads; the slave side is the conditioner.
interface button_cond_if #(
    parameter int BTN_N = 3
);
    logic [BTN_N-1:0] btn_in;
    logic [BTN_N-1:0] out;
    logic [BTN_N-1:0] ondn;
    logic [BTN_N-1:0] onup;
    logic [BTN_N-1:0] rpt;

    modport master (
        output btn_in,
        input  out,
        input  ondn,
        input  onup,
        input  rpt
    );

    modport slave (
        input  btn_in,
        output out,
        output ondn,
        output onup,
        output rpt
    );
endinterface

// File: rtl/button_cond.sv
// Multi-channel button conditioner: 2-flop sync, polarity fix, debounce,
// press/release strobes and auto-repeat, all in the clk_pix domain.
module button_cond #(
    parameter int               BTN_N      = 3,
    parameter logic [BTN_N-1:0] ACTIVE_LOW = '0,
    parameter int               DEB_CYCLES = 65536,
    parameter int               RPT_DELAY  = 12000000,
    parameter int               RPT_RATE   = 3000000
) (
    input  logic         clk_pix,
    input  logic         rst_pix,
    button_cond_if.slave bus
);
    localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int DW      = $clog2(DEB_CYCLES);
    localparam int RW      = $clog2(RPT_MAX);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(RPT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_e;

    logic [BTN_N-1:0] sync1_q, sync2_q;
    logic [BTN_N-1:0] out_q, out_d;
    logic [BTN_N-1:0] ondn_q, ondn_d;
    logic [BTN_N-1:0] onup_q, onup_d;
    logic [BTN_N-1:0] rpt_q, rpt_d;
    logic [BTN_N-1:0] rise, fall;
    logic [DW-1:0]    cnt_q  [BTN_N];
    logic [DW-1:0]    cnt_d  [BTN_N];
    logic [RW-1:0]    rcnt_q [BTN_N];
    logic [RW-1:0]    rcnt_d [BTN_N];
    rpt_state_e       state_q [BTN_N];
    rpt_state_e       state_d [BTN_N];

    // Sync stages reset to 0, so a held active-low pad reads as released
    // until it has crossed the chain.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking so sync2_q takes the old sync1_q, giving two real stages.
            sync1_q <= bus.btn_in ^ ACTIVE_LOW;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        out_d  = out_q;
        cnt_d  = cnt_q;
        rise   = '0;
        fall   = '0;
        ondn_d = '0;
        onup_d = '0;
        for (int i = 0; i < BTN_N; i++) begin
            if (sync2_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                out_d[i]  = sync2_q[i];
                cnt_d[i]  = '0;
                rise[i]   = sync2_q[i];
                fall[i]   = ~sync2_q[i];
                ondn_d[i] = sync2_q[i];
                onup_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end
        end
    end

    // Release overrides everything, including a coincident repeat terminal count.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rpt_d   = '0;
        for (int i = 0; i < BTN_N; i++) begin
            if (fall[i]) begin
                state_d[i] = IDLE;
                rcnt_d[i]  = '0;
            end else begin
                unique case (state_q[i])
                    IDLE: begin
                        if (rise[i]) begin
                            rpt_d[i]   = 1'b1;
                            rcnt_d[i]  = '0;
                            state_d[i] = DELAY;
                        end
                    end
                    DELAY: begin
                        if (rcnt_q[i] == DELAY_LAST) begin
                            rpt_d[i]   = 1'b1;
                            rcnt_d[i]  = '0;
                            state_d[i] = REPEAT;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1);
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q[i] == RATE_LAST) begin
                            rpt_d[i]  = 1'b1;
                            rcnt_d[i] = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        rcnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            out_q  <= '0;
            ondn_q <= '0;
            onup_q <= '0;
            rpt_q  <= '0;
            for (int i = 0; i < BTN_N; i++) begin
                cnt_q[i]   <= '0;
                rcnt_q[i]  <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            out_q   <= out_d;
            ondn_q  <= ondn_d;
            onup_q  <= onup_d;
            rpt_q   <= rpt_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.ondn = ondn_q;
    assign bus.onup = onup_q;
    assign bus.rpt  = rpt_q;
endmodule
